// File: rtl/mem_pkg.sv
// mem_pkg: shared encodings and helpers for the MEM-stage data memory access controller
package mem_pkg;

    typedef enum logic [3:0] {
        OP_NONE = 4'd0,
        OP_LB   = 4'd1,
        OP_LBU  = 4'd2,
        OP_LH   = 4'd3,
        OP_LHU  = 4'd4,
        OP_LW   = 4'd5,
        OP_SB   = 4'd6,
        OP_SH   = 4'd7,
        OP_SW   = 4'd8
    } mem_op_e;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_BUSY,
        ST_DONE
    } state_e;

    localparam logic [3:0] SEL_BYTE = 4'b0001;
    localparam logic [3:0] SEL_HALF = 4'b0011;
    localparam logic [3:0] SEL_WORD = 4'b1111;
    localparam int SIGN_BIT_BYTE = 7;
    localparam int SIGN_BIT_HALF = 15;

    // Access width: 0 none, 1 byte, 2 half, 3 word; unknown encodings count as none
    function automatic logic [1:0] op_size(input logic [3:0] op);
        return (op == OP_LB || op == OP_LBU || op == OP_SB) ? 2'd1 :
               (op == OP_LH || op == OP_LHU || op == OP_SH) ? 2'd2 :
               (op == OP_LW || op == OP_SW)                 ? 2'd3 : 2'd0;
    endfunction

    function automatic logic op_valid(input logic [3:0] op);
        return op_size(op) != 2'd0;
    endfunction

    function automatic logic op_store(input logic [3:0] op);
        return op == OP_SB || op == OP_SH || op == OP_SW;
    endfunction

    function automatic logic op_load(input logic [3:0] op);
        return op_valid(op) && !op_store(op);
    endfunction

    function automatic logic op_misaligned(input logic [3:0] op, input logic [1:0] lo);
        return (op_size(op) == 2'd2) ? lo[0] : (op_size(op) == 2'd3) ? |lo : 1'b0;
    endfunction

endpackage

// File: rtl/mem_lane_fmt.sv
// mem_lane_fmt: byte-lane selects, store-data replication and load-data extension
module mem_lane_fmt
    import mem_pkg::*;
(
    input  logic [3:0]  op_i,
    input  logic [1:0]  addr_lo_i,
    input  logic [31:0] wdata_i,
    input  logic [31:0] rdata_i,
    output logic [3:0]  sel_o,
    output logic [31:0] wdata_o,
    output logic [31:0] rdata_o
);

    logic [1:0]  size;
    logic [7:0]  byte_v;
    logic [15:0] half_v;

    // Pick the addressed lanes and extend loaded bytes/halves to a full word
    always_comb begin
        size    = op_size(op_i);
        byte_v  = rdata_i[{addr_lo_i, 3'b000} +: 8];
        half_v  = addr_lo_i[1] ? rdata_i[31:16] : rdata_i[15:0];
        sel_o   = (size == 2'd1) ? (SEL_BYTE << addr_lo_i) :
                  (size == 2'd2) ? (addr_lo_i[1] ? (SEL_HALF << 2) : SEL_HALF) :
                  (size == 2'd3) ? SEL_WORD : 4'b0000;
        wdata_o = (size == 2'd1) ? {4{wdata_i[7:0]}} :
                  (size == 2'd2) ? {2{wdata_i[15:0]}} : wdata_i;
        rdata_o = (op_i == OP_LB)  ? {{24{byte_v[SIGN_BIT_BYTE]}}, byte_v} :
                  (op_i == OP_LBU) ? {24'b0, byte_v} :
                  (op_i == OP_LH)  ? {{16{half_v[SIGN_BIT_HALF]}}, half_v} :
                  (op_i == OP_LHU) ? {16'b0, half_v} : rdata_i;
    end

endmodule

// File: rtl/mem_access_ctrl.sv
// mem_access_ctrl: sequences MEM-stage loads/stores over a req/ack bus and stalls the pipeline meanwhile
module mem_access_ctrl
    import mem_pkg::*;
#(
    parameter int TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [3:0]  mem_op_i,
    input  logic [31:0] mem_addr_i,
    input  logic [31:0] mem_wdata_i,
    input  logic        flush_i,
    input  logic        write_reg_en_i,
    input  logic [4:0]  write_reg_addr_i,
    input  logic [31:0] write_reg_data_i,
    output logic        bus_req_o,
    output logic        bus_we_o,
    output logic [31:0] bus_addr_o,
    output logic [3:0]  bus_sel_o,
    output logic [31:0] bus_wdata_o,
    input  logic        bus_ack_i,
    input  logic [31:0] bus_rdata_i,
    output logic        stall_req_o,
    output logic        misalign_o,
    output logic        bus_err_o,
    output logic        write_reg_en_o,
    output logic [4:0]  write_reg_addr_o,
    output logic [31:0] write_reg_data_o
);

    localparam int CW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(TIMEOUT - 1);

    state_e        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          kill_q, kill_d;
    logic          err_q, err_d;
    logic          req_q, req_d;
    logic          we_q, we_d;
    logic [31:0]   addr_q, addr_d;
    logic [3:0]    sel_q, sel_d;
    logic [31:0]   wdata_q, wdata_d;
    logic [31:0]   rdata_q, rdata_d;
    logic [3:0]    op_q, op_d;
    logic [1:0]    lo_q, lo_d;

    logic          idle, done, valid, mis, start;
    logic [3:0]    fmt_op;
    logic [1:0]    fmt_lo;
    logic [3:0]    fmt_sel;
    logic [31:0]   fmt_wdata, fmt_rdata;

    assign idle   = state_q == ST_IDLE;
    assign done   = state_q == ST_DONE;
    assign valid  = op_valid(mem_op_i);
    assign mis    = valid && op_misaligned(mem_op_i, mem_addr_i[1:0]);
    assign start  = idle && valid && !mis;
    // In IDLE the formatter sees the new op; afterwards it sees the latched one
    assign fmt_op = idle ? mem_op_i : op_q;
    assign fmt_lo = idle ? mem_addr_i[1:0] : lo_q;

    mem_lane_fmt u_fmt (
        .op_i      (fmt_op),
        .addr_lo_i (fmt_lo),
        .wdata_i   (mem_wdata_i),
        .rdata_i   (bus_rdata_i),
        .sel_o     (fmt_sel),
        .wdata_o   (fmt_wdata),
        .rdata_o   (fmt_rdata)
    );

    // State, bus and capture registers; reset drops bus_req_o immediately
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            kill_q  <= 1'b0;
            err_q   <= 1'b0;
            req_q   <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            sel_q   <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            op_q    <= '0;
            lo_q    <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            kill_q  <= kill_d;
            err_q   <= err_d;
            req_q   <= req_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            sel_q   <= sel_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            op_q    <= op_d;
            lo_q    <= lo_d;
        end
    end

    // Next-state: launch in IDLE, wait for ack or timeout in BUSY, present result for one DONE cycle
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        kill_d  = kill_q;
        err_d   = 1'b0;
        req_d   = req_q;
        we_d    = we_q;
        addr_d  = addr_q;
        sel_d   = sel_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        op_d    = op_q;
        lo_d    = lo_q;
        unique case (state_q)
            ST_IDLE: if (start) begin
                state_d = ST_BUSY;
                cnt_d   = '0;
                kill_d  = flush_i;
                req_d   = 1'b1;
                we_d    = op_store(mem_op_i);
                addr_d  = {mem_addr_i[31:2], 2'b00};
                sel_d   = fmt_sel;
                wdata_d = fmt_wdata;
                op_d    = mem_op_i;
                lo_d    = mem_addr_i[1:0];
            end
            ST_BUSY: begin
                cnt_d  = cnt_q + CW'(1);
                kill_d = kill_q | flush_i;
                if (bus_ack_i) begin
                    state_d = ST_DONE;
                    req_d   = 1'b0;
                    rdata_d = fmt_rdata;
                end else if (cnt_q == CNT_MAX) begin
                    state_d = ST_DONE;
                    req_d   = 1'b0;
                    err_d   = 1'b1;
                    kill_d  = 1'b1;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
                kill_d  = 1'b0;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Pipeline-facing outputs; everything reads 0 while reset is held
    always_comb begin
        stall_req_o      = !rst && (start || state_q == ST_BUSY);
        misalign_o       = !rst && idle && mis;
        write_reg_en_o   = !rst && (idle ? (!valid && write_reg_en_i) :
                           done ? (op_load(op_q) && write_reg_en_i && !kill_q && !flush_i) : 1'b0);
        write_reg_addr_o = rst ? 5'd0 : write_reg_addr_i;
        write_reg_data_o = rst ? 32'd0 : (done && op_load(op_q)) ? rdata_q : write_reg_data_i;
    end

    assign bus_req_o   = req_q;
    assign bus_we_o    = we_q;
    assign bus_addr_o  = addr_q;
    assign bus_sel_o   = sel_q;
    assign bus_wdata_o = wdata_q;
    assign bus_err_o   = err_q;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// tb_mem_access_ctrl: directed checks of passthrough, loads, stores, misalign, timeout, flush and reset
module tb_mem_access_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [3:0]  mem_op_i = '0;
    logic [31:0] mem_addr_i = '0;
    logic [31:0] mem_wdata_i = '0;
    logic        flush_i = 1'b0;
    logic        write_reg_en_i = 1'b0;
    logic [4:0]  write_reg_addr_i = '0;
    logic [31:0] write_reg_data_i = '0;
    logic        bus_req_o, bus_we_o;
    logic [31:0] bus_addr_o, bus_wdata_o;
    logic [3:0]  bus_sel_o;
    logic        bus_ack_i = 1'b0;
    logic [31:0] bus_rdata_i = '0;
    logic        stall_req_o, misalign_o, bus_err_o, write_reg_en_o;
    logic [4:0]  write_reg_addr_o;
    logic [31:0] write_reg_data_o;

    int total = 0;
    int bad = 0;
    int n_busy;
    int seen_err;

    mem_access_ctrl #(.TIMEOUT(16)) dut (
        .clk              (clk),
        .rst              (rst),
        .mem_op_i         (mem_op_i),
        .mem_addr_i       (mem_addr_i),
        .mem_wdata_i      (mem_wdata_i),
        .flush_i          (flush_i),
        .write_reg_en_i   (write_reg_en_i),
        .write_reg_addr_i (write_reg_addr_i),
        .write_reg_data_i (write_reg_data_i),
        .bus_req_o        (bus_req_o),
        .bus_we_o         (bus_we_o),
        .bus_addr_o       (bus_addr_o),
        .bus_sel_o        (bus_sel_o),
        .bus_wdata_o      (bus_wdata_o),
        .bus_ack_i        (bus_ack_i),
        .bus_rdata_i      (bus_rdata_i),
        .stall_req_o      (stall_req_o),
        .misalign_o       (misalign_o),
        .bus_err_o        (bus_err_o),
        .write_reg_en_o   (write_reg_en_o),
        .write_reg_addr_o (write_reg_addr_o),
        .write_reg_data_o (write_reg_data_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic nxt;
        @(posedge clk);
        #1;
    endtask

    task automatic smp;
        @(negedge clk);
    endtask

    initial begin
        smp;
        chk("rst_req", 32'(bus_req_o), 0);
        chk("rst_stall", 32'(stall_req_o), 0);
        chk("rst_en", 32'(write_reg_en_o), 0);
        chk("rst_err", 32'(bus_err_o), 0);
        chk("rst_sel", 32'(bus_sel_o), 0);
        nxt;
        rst = 1'b0;
        mem_op_i = 4'd0; write_reg_en_i = 1'b1; write_reg_addr_i = 5'd3; write_reg_data_i = 32'h1234;
        smp;
        chk("none_data", write_reg_data_o, 32'h1234);
        chk("none_addr", 32'(write_reg_addr_o), 3);
        chk("none_en", 32'(write_reg_en_o), 1);
        chk("none_stall", 32'(stall_req_o), 0);
        chk("none_req", 32'(bus_req_o), 0);
        nxt;
        mem_op_i = 4'd1; mem_addr_i = 32'h103; write_reg_addr_i = 5'd7;
        smp;
        chk("lb_stall0", 32'(stall_req_o), 1);
        chk("lb_en0", 32'(write_reg_en_o), 0);
        nxt;
        bus_ack_i = 1'b1; bus_rdata_i = 32'h8000_0000;
        smp;
        chk("lb_req", 32'(bus_req_o), 1);
        chk("lb_sel", 32'(bus_sel_o), 32'h8);
        chk("lb_addr", bus_addr_o, 32'h100);
        chk("lb_we", 32'(bus_we_o), 0);
        chk("lb_stall1", 32'(stall_req_o), 1);
        nxt;
        bus_ack_i = 1'b0;
        smp;
        chk("lb_stall2", 32'(stall_req_o), 0);
        chk("lb_en", 32'(write_reg_en_o), 1);
        chk("lb_data", write_reg_data_o, 32'hFFFF_FF80);
        chk("lb_req_off", 32'(bus_req_o), 0);
        nxt;
        mem_op_i = 4'd7; mem_addr_i = 32'h202; mem_wdata_i = 32'hABCD;
        smp;
        chk("sh_stall0", 32'(stall_req_o), 1);
        nxt;
        smp;
        chk("sh_we", 32'(bus_we_o), 1);
        chk("sh_sel", 32'(bus_sel_o), 32'hC);
        chk("sh_wdata", bus_wdata_o, 32'hABCD_ABCD);
        chk("sh_addr", bus_addr_o, 32'h200);
        nxt;
        nxt;
        bus_ack_i = 1'b1;
        smp;
        chk("sh_stall3", 32'(stall_req_o), 1);
        nxt;
        bus_ack_i = 1'b0;
        smp;
        chk("sh_en", 32'(write_reg_en_o), 0);
        chk("sh_stall_done", 32'(stall_req_o), 0);
        nxt;
        mem_op_i = 4'd5; mem_addr_i = 32'h101;
        smp;
        chk("mis_flag", 32'(misalign_o), 1);
        chk("mis_stall", 32'(stall_req_o), 0);
        chk("mis_en", 32'(write_reg_en_o), 0);
        nxt;
        smp;
        chk("mis_req", 32'(bus_req_o), 0);
        nxt;
        mem_op_i = 4'd0;
        smp;
        chk("mis_clear", 32'(misalign_o), 0);
        nxt;
        mem_op_i = 4'd5; mem_addr_i = 32'h400;
        n_busy = 0;
        seen_err = 0;
        for (int i = 0; i < 40; i++) begin
            nxt;
            smp;
            if (bus_err_o) begin
                seen_err = 1;
                break;
            end
            n_busy++;
        end
        chk("tmo_cycles", n_busy, 16);
        chk("tmo_err", seen_err, 1);
        chk("tmo_en", 32'(write_reg_en_o), 0);
        chk("tmo_stall", 32'(stall_req_o), 0);
        nxt;
        mem_op_i = 4'd0;
        smp;
        chk("tmo_err_pulse", 32'(bus_err_o), 0);
        chk("tmo_req", 32'(bus_req_o), 0);
        nxt;
        mem_op_i = 4'd4; mem_addr_i = 32'h302;
        smp;
        chk("lhu_stall0", 32'(stall_req_o), 1);
        nxt;
        flush_i = 1'b1;
        smp;
        chk("lhu_stall1", 32'(stall_req_o), 1);
        nxt;
        flush_i = 1'b0; bus_ack_i = 1'b1; bus_rdata_i = 32'h1234_5678;
        smp;
        nxt;
        bus_ack_i = 1'b0;
        smp;
        chk("lhu_flush_en", 32'(write_reg_en_o), 0);
        chk("lhu_stall_done", 32'(stall_req_o), 0);
        nxt;
        mem_op_i = 4'd3;
        nxt;
        bus_ack_i = 1'b1; bus_rdata_i = 32'h8001_0000;
        nxt;
        bus_ack_i = 1'b0;
        smp;
        chk("lh_en", 32'(write_reg_en_o), 1);
        chk("lh_data", write_reg_data_o, 32'hFFFF_8001);
        nxt;
        mem_op_i = 4'd5; mem_addr_i = 32'h500;
        nxt;
        smp;
        chk("rst_busy_req", 32'(bus_req_o), 1);
        #2 rst = 1'b1;
        #1;
        chk("arst_req", 32'(bus_req_o), 0);
        chk("arst_stall", 32'(stall_req_o), 0);
        chk("arst_en", 32'(write_reg_en_o), 0);
        chk("arst_data", write_reg_data_o, 0);
        chk("arst_addr", 32'(write_reg_addr_o), 0);
        nxt;
        rst = 1'b0; mem_op_i = 4'd0; bus_ack_i = 1'b1;
        smp;
        chk("late_ack_req", 32'(bus_req_o), 0);
        chk("late_ack_stall", 32'(stall_req_o), 0);
        nxt;
        bus_ack_i = 1'b0;
        smp;
        chk("late_ack_err", 32'(bus_err_o), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
